nh_lcd_pixel_feeder: RTL and testbench

NH_LCD_PIXEL_FEEDER -- requirements
Module: nh_lcd_pixel_feeder

---
 rtl/nh_lcd_pixel_feeder.sv | 216 +++++++++++++++++++++
 tb/tb_nh_lcd_pixel_feeder.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nh_lcd_pixel_feeder.sv
// Pixel stream to ping-pong FIFO feeder: frames the incoming AXI-style pixels
// by internal width/height counters and writes them in channel-sized bursts.
module nh_lcd_pixel_feeder #(
    parameter int DATAS_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_enable,
    input  logic [31:0]            i_image_width,
    input  logic [31:0]            i_image_height,
    input  logic                   i_s_tvalid,
    input  logic [DATAS_WIDTH-1:0] i_s_tdata,
    input  logic                   i_s_tlast,
    input  logic                   i_s_tuser,
    output logic                   o_s_tready,
    input  logic [1:0]             i_fifo_rdy,
    output logic [1:0]             o_fifo_act,
    output logic                   o_fifo_stb,
    input  logic [23:0]            i_fifo_size,
    output logic [DATAS_WIDTH:0]   o_fifo_data,
    output logic                   o_frame_done,
    output logic                   o_sync_error
);

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_IDLE,
        ST_ACQUIRE,
        ST_FILL,
        ST_RELEASE
    } state_t;

    state_t                 state_q, state_d;
    logic                   held_q, held_d;
    logic [DATAS_WIDTH-1:0] held_data_q, held_data_d;
    logic                   held_last_q, held_last_d;
    logic [31:0]            pix_count_q, pix_count_d;
    logic [31:0]            line_count_q, line_count_d;
    logic [31:0]            burst_count_q, burst_count_d;
    logic [1:0]             act_q, act_d;
    logic                   stb_q, stb_d;
    logic [DATAS_WIDTH:0]   data_q, data_d;
    logic                   frame_done_q, frame_done_d;
    logic                   sync_error_q, sync_error_d;
    logic                   frame_end_q, frame_end_d;
    logic                   ready_en_q, ready_en_d;

    logic                   handshake;
    logic                   line_last;
    logic                   first_pix;
    logic [31:0]            fifo_size32;
    logic                   wr_en;
    logic [DATAS_WIDTH-1:0] wr_pix;
    logic                   wr_tlast;

    assign fifo_size32 = {8'd0, i_fifo_size};
    assign line_last   = (pix_count_q == i_image_width - 32'd1);
    assign first_pix   = (pix_count_q == 32'd0) && (line_count_q == 32'd0);

    always_comb begin
        state_d       = state_q;
        held_d        = held_q;
        held_data_d   = held_data_q;
        held_last_d   = held_last_q;
        pix_count_d   = pix_count_q;
        line_count_d  = line_count_q;
        burst_count_d = burst_count_q;
        act_d         = act_q;
        stb_d         = 1'b0;
        data_d        = data_q;
        frame_done_d  = 1'b0;
        sync_error_d  = 1'b0;
        frame_end_d   = frame_end_q;
        ready_en_d    = 1'b1;
        wr_en         = 1'b0;
        wr_pix        = held_data_q;
        wr_tlast      = held_last_q;

        // ready_en_q keeps tready low until the first edge after reset release
        o_s_tready = 1'b0;
        if (ready_en_q) begin
            if (state_q == ST_SYNC) begin
                o_s_tready = 1'b1;
            end else if (state_q == ST_FILL && !held_q && burst_count_q < fifo_size32) begin
                o_s_tready = 1'b1;
            end
        end
        handshake = o_s_tready && i_s_tvalid;

        case (state_q)
            ST_SYNC: begin
                pix_count_d  = 32'd0;
                line_count_d = 32'd0;
                frame_end_d  = 1'b0;
                if (handshake && i_s_tuser) begin
                    held_d      = 1'b1;
                    held_data_d = i_s_tdata;
                    held_last_d = i_s_tlast;
                    state_d     = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!i_enable) begin
                    held_d  = 1'b0;
                    state_d = ST_SYNC;
                end else if (i_fifo_rdy != 2'b00 && fifo_size32 != 32'd0) begin
                    state_d = ST_ACQUIRE;
                end
            end
            ST_ACQUIRE: begin
                act_d         = i_fifo_rdy[0] ? 2'b01 : 2'b10;
                burst_count_d = 32'd0;
                state_d       = ST_FILL;
            end
            ST_FILL: begin
                if (held_q) begin
                    wr_en  = 1'b1;
                    held_d = 1'b0;
                end else if (handshake) begin
                    if (i_s_tuser && !first_pix) begin
                        // Unexpected start of frame: keep it as pixel 0 of a fresh frame
                        sync_error_d = 1'b1;
                        held_d       = 1'b1;
                        held_data_d  = i_s_tdata;
                        held_last_d  = i_s_tlast;
                        pix_count_d  = 32'd0;
                        line_count_d = 32'd0;
                        frame_end_d  = 1'b0;
                        state_d      = ST_RELEASE;
                    end else begin
                        wr_en    = 1'b1;
                        wr_pix   = i_s_tdata;
                        wr_tlast = i_s_tlast;
                    end
                end
                if (wr_en) begin
                    stb_d         = 1'b1;
                    data_d        = {line_last, wr_pix};
                    sync_error_d  = (wr_tlast != line_last);
                    burst_count_d = burst_count_q + 32'd1;
                    if (line_last) begin
                        pix_count_d = 32'd0;
                        state_d     = ST_RELEASE;
                        if (line_count_q == i_image_height - 32'd1) begin
                            frame_end_d = 1'b1;
                        end else begin
                            line_count_d = line_count_q + 32'd1;
                        end
                    end else begin
                        pix_count_d = pix_count_q + 32'd1;
                        if (burst_count_q + 32'd1 >= fifo_size32) begin
                            state_d = ST_RELEASE;
                        end
                    end
                end
            end
            ST_RELEASE: begin
                act_d = 2'b00;
                if (frame_end_q) begin
                    frame_done_d = 1'b1;
                    frame_end_d  = 1'b0;
                    line_count_d = 32'd0;
                    pix_count_d  = 32'd0;
                    held_d       = 1'b0;
                    state_d      = ST_SYNC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_SYNC;
            held_q        <= 1'b0;
            held_data_q   <= '0;
            held_last_q   <= 1'b0;
            pix_count_q   <= 32'd0;
            line_count_q  <= 32'd0;
            burst_count_q <= 32'd0;
            act_q         <= 2'b00;
            stb_q         <= 1'b0;
            data_q        <= '0;
            frame_done_q  <= 1'b0;
            sync_error_q  <= 1'b0;
            frame_end_q   <= 1'b0;
            ready_en_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            held_q        <= held_d;
            held_data_q   <= held_data_d;
            held_last_q   <= held_last_d;
            pix_count_q   <= pix_count_d;
            line_count_q  <= line_count_d;
            burst_count_q <= burst_count_d;
            act_q         <= act_d;
            stb_q         <= stb_d;
            data_q        <= data_d;
            frame_done_q  <= frame_done_d;
            sync_error_q  <= sync_error_d;
            frame_end_q   <= frame_end_d;
            ready_en_q    <= ready_en_d;
        end
    end

    assign o_fifo_act   = act_q;
    assign o_fifo_stb   = stb_q;
    assign o_fifo_data  = data_q;
    assign o_frame_done = frame_done_q;
    assign o_sync_error = sync_error_q;

endmodule

// File: tb/tb_nh_lcd_pixel_feeder.sv
// Scoreboard bench for nh_lcd_pixel_feeder: a frame-level model predicts every
// FIFO word from accepted pixels; a monitor pops and compares on each strobe.
module tb_nh_lcd_pixel_feeder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_enable;
    logic [31:0] i_image_width;
    logic [31:0] i_image_height;
    logic        i_s_tvalid;
    logic [23:0] i_s_tdata;
    logic        i_s_tlast;
    logic        i_s_tuser;
    logic        o_s_tready;
    logic [1:0]  i_fifo_rdy;
    logic [1:0]  o_fifo_act;
    logic        o_fifo_stb;
    logic [23:0] i_fifo_size;
    logic [24:0] o_fifo_data;
    logic        o_frame_done;
    logic        o_sync_error;

    always #5 clk = ~clk;

    nh_lcd_pixel_feeder #(.DATAS_WIDTH(24)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_enable       (i_enable),
        .i_image_width  (i_image_width),
        .i_image_height (i_image_height),
        .i_s_tvalid     (i_s_tvalid),
        .i_s_tdata      (i_s_tdata),
        .i_s_tlast      (i_s_tlast),
        .i_s_tuser      (i_s_tuser),
        .o_s_tready     (o_s_tready),
        .i_fifo_rdy     (i_fifo_rdy),
        .o_fifo_act     (o_fifo_act),
        .o_fifo_stb     (o_fifo_stb),
        .i_fifo_size    (i_fifo_size),
        .o_fifo_data    (o_fifo_data),
        .o_frame_done   (o_frame_done),
        .o_sync_error   (o_sync_error)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit aborted  = 0;

    // Reference model state: framing is tracked per frame from accepted pixels
    logic [24:0] exp_q[$];
    bit          m_in_frame;
    int unsigned m_pix;
    int unsigned m_line;
    int          exp_err, exp_done;
    int          got_err, got_done, got_stb;
    int          bursts[$];
    int          burst_len;
    logic [1:0]  prev_act;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, expv, $time);
        end
    endtask

    function automatic void model_write(input logic [23:0] d, input bit tl);
        bit ll;
        ll = (m_pix == i_image_width - 32'd1);
        exp_q.push_back({ll, d});
        if (tl != ll) exp_err++;
        if (ll) begin
            m_pix = 0;
            if (m_line == i_image_height - 32'd1) begin
                exp_done++;
                m_in_frame = 0;
                m_line = 0;
            end else begin
                m_line++;
            end
        end else begin
            m_pix++;
        end
    endfunction

    function automatic void model_accept(input logic [23:0] d, input bit tl, input bit tu);
        if (!m_in_frame) begin
            if (tu) begin
                m_in_frame = 1;
                m_pix = 0;
                m_line = 0;
                model_write(d, tl);
            end
        end else if (tu) begin
            exp_err++;
            m_pix = 0;
            m_line = 0;
            model_write(d, tl);
        end else begin
            model_write(d, tl);
        end
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        bursts.delete();
        m_in_frame = 0;
        m_pix = 0;
        m_line = 0;
        exp_err = 0;
        exp_done = 0;
        got_err = 0;
        got_done = 0;
        got_stb = 0;
    endfunction

    // Monitor: compares strobed words, tracks bursts, feeds accepted pixels to the model
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_fifo_stb) begin
                got_stb++;
                burst_len++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_stb: got data 0x%0h, expected no write", o_fifo_data);
                end else begin
                    logic [24:0] e;
                    e = exp_q.pop_front();
                    if (o_fifo_data !== e) begin
                        n_fail++;
                        $display("FAIL fifo_data: got 0x%0h, expected 0x%0h at %0t", o_fifo_data, e, $time);
                    end
                end
                check("act_onehot_on_stb", 64'(o_fifo_act == 2'b01 || o_fifo_act == 2'b10), 64'd1);
            end
            if (prev_act == 2'b00 && o_fifo_act != 2'b00)
                check("act_select", 64'(o_fifo_act), 64'(i_fifo_rdy[0] ? 2'b01 : 2'b10));
            if (prev_act != 2'b00 && o_fifo_act == 2'b00) begin
                bursts.push_back(burst_len);
                burst_len = 0;
            end
            if (o_frame_done) got_done++;
            if (o_sync_error) got_err++;
            if (i_s_tvalid && o_s_tready) model_accept(i_s_tdata, i_s_tlast, i_s_tuser);
            prev_act = o_fifo_act;
        end else begin
            prev_act = 2'b00;
            burst_len = 0;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        i_s_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [23:0] d, input bit l, input bit u);
        int g;
        if (aborted) return;
        if ($urandom_range(0, 3) == 0) begin
            i_s_tvalid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        i_s_tvalid = 1'b1;
        i_s_tdata  = d;
        i_s_tlast  = l;
        i_s_tuser  = u;
        g = 0;
        forever begin
            @(negedge clk);
            if (o_s_tready) break;
            g++;
            if (g >= 2000) begin
                aborted = 1;
                n_checks++;
                n_fail++;
                $display("FAIL handshake_timeout: tready stayed 0, expected acceptance within 2000 cycles");
                break;
            end
        end
        @(posedge clk);
        #1;
        i_s_tvalid = 1'b0;
    endtask

    task automatic send_frame(input bit flip_en);
        for (int l = 0; l < int'(i_image_height); l++) begin
            for (int p = 0; p < int'(i_image_width); p++) begin
                bit tl;
                tl = (p == int'(i_image_width) - 1);
                if (flip_en && $urandom_range(0, 7) == 0) tl = !tl;
                send(24'($urandom()), tl, (p == 0 && l == 0));
            end
        end
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || o_fifo_act != 2'b00) && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 1000) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d words still expected, act=%b", exp_q.size(), o_fifo_act);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic phase_end(input string tag);
        check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_sync_errors"}, 64'(got_err), 64'(exp_err));
        check({tag, "_frame_done"}, 64'(got_done), 64'(exp_done));
    endtask

    task automatic check_bursts(input string tag, input int e[$]);
        check({tag, "_burst_n"}, 64'(bursts.size()), 64'(e.size()));
        for (int i = 0; i < e.size() && i < bursts.size(); i++)
            check({tag, "_burst_len"}, 64'(bursts[i]), 64'(e[i]));
    endtask

    task automatic config_run(input int w, input int h, input int s, input logic [1:0] r);
        i_image_width  = 32'(w);
        i_image_height = 32'(h);
        i_fifo_size    = 24'(s);
        i_fifo_rdy     = r;
    endtask

    initial begin
        #900000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, expected finish before 900us");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        rst_n = 1'b0;
        i_enable = 1'b1;
        i_s_tvalid = 1'b0;
        i_s_tdata = 24'd0;
        i_s_tlast = 1'b0;
        i_s_tuser = 1'b0;
        config_run(4, 2, 16, 2'b01);
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_tready", 64'(o_s_tready), 64'd0);
        check("rst_act", 64'(o_fifo_act), 64'd0);
        check("rst_stb", 64'(o_fifo_stb), 64'd0);
        check("rst_data", 64'(o_fifo_data), 64'd0);
        check("rst_frame_done", 64'(o_frame_done), 64'd0);
        check("rst_sync_error", 64'(o_sync_error), 64'd0);

        // Two-line frame fits in one channel per line
        config_run(4, 2, 16, 2'b01);
        do_reset();
        send_frame(0);
        wait_drain();
        check_bursts("two_lines", '{4, 4});
        check("two_lines_stb", 64'(got_stb), 64'd8);
        phase_end("two_lines");

        // Line spread across small channels
        config_run(8, 1, 3, 2'b10);
        do_reset();
        send_frame(0);
        wait_drain();
        check_bursts("split_line", '{3, 3, 2});
        phase_end("split_line");

        // Pixels before start of frame are discarded
        config_run(4, 1, 16, 2'b11);
        do_reset();
        for (int i = 0; i < 3; i++) send(24'($urandom()), 1'($urandom_range(0, 1)), 1'b0);
        send_frame(0);
        wait_drain();
        check("pre_sof_stb", 64'(got_stb), 64'd4);
        phase_end("pre_sof");

        // Early tlast on pixel 3 of 4
        config_run(4, 1, 16, 2'b01);
        do_reset();
        send(24'h112233, 1'b0, 1'b1);
        send(24'h445566, 1'b0, 1'b0);
        send(24'h778899, 1'b1, 1'b0);
        send(24'hAABBCC, 1'b0, 1'b0);
        wait_drain();
        check("early_tlast_errors", 64'(got_err), 64'd2);
        phase_end("early_tlast");

        // Start of frame arriving mid-frame restarts framing
        config_run(4, 2, 16, 2'b01);
        do_reset();
        for (int i = 0; i < 6; i++) send(24'($urandom()), (i == 3), (i == 0));
        send_frame(0);
        wait_drain();
        check("mid_sof_stb", 64'(got_stb), 64'd14);
        phase_end("mid_sof");

        // Asynchronous reset in the middle of a burst
        config_run(8, 1, 16, 2'b01);
        do_reset();
        send(24'h0A0B0C, 1'b0, 1'b1);
        send(24'h0D0E0F, 1'b0, 1'b0);
        send(24'h101112, 1'b0, 1'b0);
        @(negedge clk);
        check("act_before_reset", 64'(o_fifo_act), 64'(2'b01));
        rst_n = 1'b0;
        #1;
        check("act_async_reset", 64'(o_fifo_act), 64'd0);
        check("stb_async_reset", 64'(o_fifo_stb), 64'd0);
        repeat (2) @(posedge clk);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(24'h555555, 1'b0, 1'b0);
        send(24'h666666, 1'b1, 1'b0);
        send_frame(0);
        wait_drain();
        check("after_reset_stb", 64'(got_stb), 64'd8);
        phase_end("after_reset");

        // Zero-depth channel is never used
        config_run(4, 1, 0, 2'b01);
        do_reset();
        send(24'h123456, 1'b0, 1'b1);
        repeat (50) @(posedge clk);
        #1;
        check("size0_stb", 64'(got_stb), 64'd0);
        check("size0_act", 64'(o_fifo_act), 64'd0);
        check("size0_tready", 64'(o_s_tready), 64'd0);

        // Random frames with random geometry, channel depth, channel choice and framing errors
        config_run(3, 2, 4, 2'b01);
        do_reset();
        for (int f = 0; f < 12 && !aborted; f++) begin
            logic [1:0] r;
            r = 2'($urandom_range(1, 3));
            config_run(int'($urandom_range(1, 6)), int'($urandom_range(1, 3)),
                       int'($urandom_range(1, 5)), r);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++)
                send(24'($urandom()), 1'($urandom_range(0, 1)), 1'b0);
            send_frame(1);
            wait_drain();
            phase_end("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
